// File: rtl/bin2bcd_disp_src.sv
// Sequential double-dabble binary-to-BCD converter feeding the 4-digit LED scanner.
// Optional leading-zero blank mask is enabled with LEADING_ZERO_BLANK_EN.
module bin2bcd_disp_src #(
   parameter int BIN_W   = 14,
   parameter int DIGITS  = 4,
   parameter int MAX_VAL = 9999
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [BIN_W-1:0]      bin_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  ovf_o,
   output logic [4*DIGITS-1:0]   bcd_o,
   output logic [DIGITS-1:0]     blank_o
);

   localparam int ACC_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam logic [BIN_W:0]     MAX_V    = (BIN_W + 1)'(MAX_VAL);
   localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(BIN_W - 1);
   localparam logic [ACC_W-1:0]   NINES    = {DIGITS{4'h9}};

   typedef enum logic {IDLE, CONV} state_t;

   state_t             state_q;
   logic [ACC_W-1:0]   acc_q;
   logic [BIN_W-1:0]   sh_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               ovfPend_q;
   logic               busy_q;
   logic               done_q;
   logic               ovf_q;
   logic [ACC_W-1:0]   bcd_q;

   logic [ACC_W-1:0]   accAdj_d;
   logic [ACC_W-1:0]   accShift_d;
   logic [ACC_W-1:0]   bcdFinal_d;
   logic               lastConv;

   // Per-nibble add-3 with no carry between nibbles, then the shift step.
   always_comb begin
      accAdj_d = acc_q;
      for (int d = 0; d < DIGITS; d++) begin
         if (acc_q[4*d +: 4] >= 4'd5)
            accAdj_d[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
      end
      accShift_d = {accAdj_d[ACC_W-2:0], sh_q[BIN_W-1]};
      bcdFinal_d = ovfPend_q ? NINES : accShift_d;
   end

   assign lastConv = (state_q == CONV) && (cnt_q == LAST_CNT);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         sh_q      <= '0;
         cnt_q     <= '0;
         ovfPend_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
         bcd_q     <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  sh_q      <= bin_i;
                  acc_q     <= '0;
                  cnt_q     <= '0;
                  ovfPend_q <= ({1'b0, bin_i} > MAX_V);
                  busy_q    <= 1'b1;
                  state_q   <= CONV;
               end
            end
            CONV: begin
               acc_q <= accShift_d;
               sh_q  <= {sh_q[BIN_W-2:0], 1'b0};
               cnt_q <= cnt_q + CNT_W'(1);
               if (lastConv) begin
                  bcd_q   <= bcdFinal_d;
                  ovf_q   <= ovfPend_q;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0] blank_q;
   logic [DIGITS-1:0] blankFinal_d;
   logic              allZero;

   // Digit i blanks when it and every more-significant digit are zero; digit 0 never blanks.
   always_comb begin
      blankFinal_d = '0;
      allZero      = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         allZero         = allZero && (accShift_d[4*i +: 4] == 4'd0);
         blankFinal_d[i] = allZero && !ovfPend_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         blank_q <= '0;
      else if (lastConv)
         blank_q <= blankFinal_d;
   end

   assign blank_o = blank_q;
`else
   assign blank_o = '0;
`endif

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign ovf_o  = ovf_q;
   assign bcd_o  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_disp_src.sv
// Self-checking bench for bin2bcd_disp_src: directed cases plus randomized values
// compared against an arithmetic decimal model.
module tb_bin2bcd_disp_src;

   localparam int BIN_W  = 14;
   localparam int DIGITS = 4;

   logic                clk = 1'b0;
   logic                reset;
   logic                start;
   logic [BIN_W-1:0]    bin;
   logic                busy;
   logic                done;
   logic                ovf;
   logic [4*DIGITS-1:0] bcd;
   logic [DIGITS-1:0]   blank;

   int checks = 0;
   int errors = 0;

   logic [15:0] prevBcd;
   logic        prevOvf;
   logic [3:0]  prevBlank;

   int busyCnt;
   int doneAt;
   bit holdOk;
   bit digitsOk;
   bit sawDone;

   bin2bcd_disp_src #(.BIN_W(BIN_W), .DIGITS(DIGITS), .MAX_VAL(9999)) dut (
      .clk_i   (clk),
      .rst_i   (reset),
      .start_i (start),
      .bin_i   (bin),
      .busy_o  (busy),
      .done_o  (done),
      .ovf_o   (ovf),
      .bcd_o   (bcd),
      .blank_o (blank)
   );

   always #5 clk = ~clk;

   // Decimal digits of the value, saturated to all nines above 9999.
   function automatic logic [15:0] refBcd(input int v);
      logic [15:0] r;
      int          x;
      r = '0;
      if (v > 9999) return 16'h9999;
      x = v;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Digit i (i>=1) is blank when the value has fewer than i+1 decimal digits.
   function automatic logic [3:0] refBlank(input int v);
      logic [3:0] r;
      int         p;
      r = '0;
`ifdef LEADING_ZERO_BLANK_EN
      p = 10;
      if (v <= 9999) begin
         for (int i = 1; i < 4; i++) begin
            r[i] = (v < p);
            p = p * 10;
         end
      end
`endif
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Runs one conversion starting at a negedge; returns at the negedge where Done is seen.
   task automatic applyStimulus(input int value, input int glitchAt, input bit holdStart);
      bin   = BIN_W'(value);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!holdStart) start = 1'b0;
      busyCnt = 0;
      doneAt  = 0;
      holdOk  = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         if (done) begin
            doneAt = n;
            break;
         end
         if (busy) busyCnt++;
         if (bcd !== prevBcd || ovf !== prevOvf || blank !== prevBlank) holdOk = 1'b0;
         if (n == glitchAt) begin
            start = 1'b1;
            bin   = BIN_W'(1111);
         end else if (!holdStart) begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      digitsOk = 1'b1;
      for (int d = 0; d < 4; d++)
         if (bcd[4*d +: 4] > 4'd9) digitsOk = 1'b0;
      checkOutput($sformatf("doneLatency(%0d)", value), 32'(doneAt), 32'd15);
      checkOutput($sformatf("busyCycles(%0d)", value), 32'(busyCnt), 32'd14);
      checkOutput($sformatf("holdDuringBusy(%0d)", value), 32'(holdOk), 32'd1);
      checkOutput($sformatf("bcd(%0d)", value), 32'(bcd), 32'(refBcd(value)));
      checkOutput($sformatf("ovf(%0d)", value), 32'(ovf), 32'(value > 9999));
      checkOutput($sformatf("blank(%0d)", value), 32'(blank), 32'(refBlank(value)));
      checkOutput($sformatf("digitRange(%0d)", value), 32'(digitsOk), 32'd1);
      prevBcd   = refBcd(value);
      prevOvf   = (value > 9999);
      prevBlank = refBlank(value);
      if (!holdStart) begin
         @(negedge clk);
         checkOutput($sformatf("donePulse(%0d)", value), 32'(done), 32'd0);
      end
   endtask

   initial begin
      int edgeVals[10];
      reset = 1'b1;
      start = 1'b0;
      bin   = '0;
      prevBcd   = '0;
      prevOvf   = 1'b0;
      prevBlank = '0;
      repeat (3) @(negedge clk);
      checkOutput("resetBusy", 32'(busy), 32'd0);
      checkOutput("resetDone", 32'(done), 32'd0);
      checkOutput("resetOvf", 32'(ovf), 32'd0);
      checkOutput("resetBcd", 32'(bcd), 32'd0);
      checkOutput("resetBlank", 32'(blank), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] basic conversion 1234");
      applyStimulus(1234, 0, 1'b0);

      $display("[TB] back-to-back 9999 then 0 with Start held");
      applyStimulus(9999, 0, 1'b1);
      applyStimulus(0, 0, 1'b0);

      $display("[TB] overflow cases");
      applyStimulus(10000, 0, 1'b0);
      applyStimulus(16383, 0, 1'b0);
      applyStimulus(42, 0, 1'b0);

      $display("[TB] Start and Bin change during conversion ignored");
      applyStimulus(5678, 5, 1'b0);
      checkOutput("glitchBcdKept", 32'(bcd), 32'h5678);
      repeat (20) @(negedge clk);
      checkOutput("glitchNoSecondDone", 32'(busy), 32'd0);

      $display("[TB] asynchronous reset mid-conversion");
      bin   = BIN_W'(4321);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checkOutput("abortBusy", 32'(busy), 32'd0);
      checkOutput("abortDone", 32'(done), 32'd0);
      checkOutput("abortBcd", 32'(bcd), 32'd0);
      checkOutput("abortOvf", 32'(ovf), 32'd0);
      checkOutput("abortBlank", 32'(blank), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      sawDone = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (done || busy) sawDone = 1'b1;
      end
      checkOutput("abortNoDone", 32'(sawDone), 32'd0);
      prevBcd   = '0;
      prevOvf   = 1'b0;
      prevBlank = '0;
      applyStimulus(7, 0, 1'b0);

      $display("[TB] decimal boundaries");
      edgeVals = '{0, 9, 10, 99, 100, 999, 1000, 9998, 9999, 10000};
      foreach (edgeVals[i]) applyStimulus(edgeVals[i], 0, 1'b0);

      $display("[TB] randomized values");
      for (int k = 0; k < 300; k++) begin
         if (k % 8 == 7)
            applyStimulus(int'($urandom_range(10000, 16383)), 0, 1'b0);
         else
            applyStimulus(int'($urandom_range(0, 9999)), 0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
